// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM: fetch/decode/exec/mem/wb over one shared memory port.
// Latency: 3 cycles (J/JR/JAL/BNE), 4 (R-type/ADDI/XORI/SW), 5 (LW), plus one per memory wait cycle.
// Backpressure: FETCH and MEM stall while mem_ready is low; a bounded stall traps to HALT.
module multicycle_control #(
  parameter int CMD_WIDTH   = 3,
  parameter int WAIT_LIMIT  = 16,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  input  logic                   zero,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic [1:0]             pc_source,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   i_or_d,
  output logic                   reg_write,
  output logic [1:0]             reg_dst,
  output logic [1:0]             mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [CMD_WIDTH-1:0]   command,
  output logic [2:0]             state,
  output logic                   retire,
  output logic                   illegal,
  output logic                   timeout,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [CMD_WIDTH-1:0] CMD_ADD = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] CMD_SUB = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CMD_SLT = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CMD_XOR = CMD_WIDTH'(3);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_JR  = 6'h08;

  // A zero-width counter is not legal, so keep at least one bit when the timeout is disabled.
  localparam int WW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_e                 state_q, state_d;
  logic [5:0]             op_q, op_d;
  logic [5:0]             funct_q, funct_d;
  logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [COUNT_WIDTH-1:0] retired_count_q, retired_count_d;
  logic                   illegal_q, illegal_d;
  logic                   timeout_q, timeout_d;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE)
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_SLT) || (fn == FN_JR);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_J) || (op == OP_JAL) ||
           (op == OP_BNE) || (op == OP_XORI) || (op == OP_ADDI);
  endfunction

  // State register and architectural trap/retire state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= S_FETCH;
      op_q            <= '0;
      funct_q         <= '0;
      wait_cnt_q      <= '0;
      retired_count_q <= '0;
      illegal_q       <= 1'b0;
      timeout_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      op_q            <= op_d;
      funct_q         <= funct_d;
      wait_cnt_q      <= wait_cnt_d;
      retired_count_q <= retired_count_d;
      illegal_q       <= illegal_d;
      timeout_q       <= timeout_d;
    end
  end

  // Next-state and datapath control; strobes are squashed while reset is held.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    funct_d    = funct_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_source  = 2'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    command    = CMD_ADD;
    retire     = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Later states only look at the latched copy, so the IR may change freely.
        op_d    = opcode;
        funct_d = funct;
        if (is_legal(opcode, funct)) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_RTYPE: begin
            if (funct_q == FN_JR) begin
              pc_write  = 1'b1;
              pc_source = 2'd3;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end else begin
              alu_src_a = 1'b1;
              command   = (funct_q == FN_SUB) ? CMD_SUB :
                          (funct_q == FN_SLT) ? CMD_SLT : CMD_ADD;
              state_d   = S_WB;
            end
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd2;
            state_d   = (op_q == OP_ADDI) ? S_WB : S_MEM;
          end
          OP_XORI: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'd3;
            command   = CMD_XOR;
            state_d   = S_WB;
          end
          OP_BNE: begin
            alu_src_a = 1'b1;
            command   = CMD_SUB;
            pc_source = 2'd1;
            pc_write  = ~zero;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          OP_J: begin
            pc_write  = 1'b1;
            pc_source = 2'd2;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            reg_write  = 1'b1;
            reg_dst    = 2'd2;
            mem_to_reg = 2'd2;
            retire     = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        i_or_d    = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
          if (mem_ready) state_d = S_WB;
        end else begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (op_q == OP_RTYPE) reg_dst = 2'd1;
        else if (op_q == OP_LW) mem_to_reg = 2'd1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Bounded memory stall: the last permitted wait cycle traps instead of waiting again.
    if ((WAIT_LIMIT > 0) && ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready &&
        (wait_cnt_q == WAIT_LAST)) begin
      timeout_d = 1'b1;
      state_d   = S_HALT;
    end

    if (!reset_n) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      retire    = 1'b0;
    end
  end

  // Wait counter and retire counter updates.
  always_comb begin
    wait_cnt_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready)
      wait_cnt_d = wait_cnt_q + WW'(1);
    retired_count_d = retired_count_q + COUNT_WIDTH'(retire);
  end

  assign state         = state_q;
  assign illegal       = illegal_q;
  assign timeout       = timeout_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with WAIT_LIMIT=4 and a 4-bit retire counter.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Each scenario task performs its own comparisons against hand-derived values.
module tb_multicycle_control;

  logic       clk, reset_n;
  logic [5:0] opcode, funct;
  logic       mem_ready, zero;
  logic       ir_write, pc_write, mem_read, mem_write, i_or_d, reg_write, alu_src_a;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
  logic [2:0] command, state;
  logic       retire, illegal, timeout;
  logic [3:0] retired_count;

  multicycle_control #(.CMD_WIDTH(3), .WAIT_LIMIT(4), .COUNT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .zero(zero), .ir_write(ir_write), .pc_write(pc_write),
    .pc_source(pc_source), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .command(command), .state(state),
    .retire(retire), .illegal(illegal), .timeout(timeout), .retired_count(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] exp_cnt;

  // Per-cycle snapshots of the last instruction run.
  logic [2:0] a_st  [20];
  logic       a_pcw [20];
  logic       a_irw [20];
  logic       a_rw  [20];
  logic       a_mw  [20];
  logic       a_mr  [20];
  logic       a_iod [20];
  logic       a_asa [20];
  logic       a_ret [20];
  logic [1:0] a_pcs [20];
  logic [1:0] a_rd  [20];
  logic [1:0] a_mtr [20];
  logic [1:0] a_asb [20];
  logic [2:0] a_cmd [20];

  // Drives one instruction from FETCH; mr_pat[c] is mem_ready in cycle c. cyc = cycles until
  // retire (or HALT), -1 if neither appears. After DECODE the IR inputs are scrambled.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic [19:0] mr_pat, output int cyc);
    bit seen_dec;
    seen_dec = 1'b0;
    cyc = -1;
    for (int i = 0; i < 20; i++) begin
      a_st[i] = 3'd7; a_pcw[i] = 0; a_irw[i] = 0; a_rw[i] = 0; a_mw[i] = 0; a_mr[i] = 0;
      a_iod[i] = 0; a_asa[i] = 0; a_ret[i] = 0; a_pcs[i] = 0; a_rd[i] = 0; a_mtr[i] = 0;
      a_asb[i] = 0; a_cmd[i] = 0;
    end
    opcode = op; funct = fn; zero = z;
    for (int c = 0; c < 20; c++) begin
      mem_ready = mr_pat[c];
      #1;
      a_st[c] = state; a_pcw[c] = pc_write; a_irw[c] = ir_write; a_rw[c] = reg_write;
      a_mw[c] = mem_write; a_mr[c] = mem_read; a_iod[c] = i_or_d; a_asa[c] = alu_src_a;
      a_ret[c] = retire; a_pcs[c] = pc_source; a_rd[c] = reg_dst; a_mtr[c] = mem_to_reg;
      a_asb[c] = alu_src_b; a_cmd[c] = command;
      if (state == 3'd1) seen_dec = 1'b1;
      if (retire === 1'b1 || state === 3'd5) cyc = c + 1;
      @(posedge clk); #1;
      if (cyc >= 0) break;
      if (seen_dec) begin opcode = 6'h3f; funct = 6'h3f; end
    end
    mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    #2;
    n_checks++; if (state !== 3'd0) $display("FAIL rst_state got %0d want 0", state); else n_pass++;
    n_checks++; if (pc_write !== 1'b0) $display("FAIL rst_pc_write got %b want 0", pc_write); else n_pass++;
    n_checks++; if (ir_write !== 1'b0) $display("FAIL rst_ir_write got %b want 0", ir_write); else n_pass++;
    n_checks++; if (retired_count !== 4'd0) $display("FAIL rst_count got %0d want 0", retired_count); else n_pass++;
    n_checks++; if ({illegal, timeout} !== 2'b00) $display("FAIL rst_traps got %b want 00", {illegal, timeout}); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    n_checks++; if (mem_read !== 1'b1) $display("FAIL rel_mem_read got %b want 1", mem_read); else n_pass++;
    n_checks++; if (ir_write !== 1'b1) $display("FAIL rel_ir_write got %b want 1", ir_write); else n_pass++;
    n_checks++; if (alu_src_b !== 2'd1) $display("FAIL rel_alu_src_b got %0d want 1", alu_src_b); else n_pass++;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_mem_wait_add();
    int cyc;
    run_instr(6'h00, 6'h20, 1'b0, 20'hFFFFC, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 6) $display("FAIL add_wait_cycles got %0d want 6", cyc); else n_pass++;
    n_checks++; if (a_irw[0] !== 1'b0) $display("FAIL add_irw_wait got %b want 0", a_irw[0]); else n_pass++;
    n_checks++; if (a_irw[2] !== 1'b1) $display("FAIL add_irw_ready got %b want 1", a_irw[2]); else n_pass++;
    n_checks++; if (a_st[5] !== 3'd4) $display("FAIL add_wb_state got %0d want 4", a_st[5]); else n_pass++;
    n_checks++; if ({a_rw[5], a_rd[5], a_mtr[5]} !== 5'b1_01_00) $display("FAIL add_wb_ctl got %b want 10100", {a_rw[5], a_rd[5], a_mtr[5]}); else n_pass++;
    n_checks++; if ({a_asa[4], a_asb[4], a_cmd[4]} !== 6'b1_00_000) $display("FAIL add_exec_ctl got %b want 100000", {a_asa[4], a_asb[4], a_cmd[4]}); else n_pass++;
    n_checks++; if (retired_count !== exp_cnt) $display("FAIL add_count got %0d want %0d", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_lw_sw();
    int cyc;
    logic any_rw;
    run_instr(6'h23, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 5) $display("FAIL lw_cycles got %0d want 5", cyc); else n_pass++;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if (a_st[c] !== 3'(c)) $display("FAIL lw_state%0d got %0d want %0d", c, a_st[c], c); else n_pass++;
    end
    n_checks++; if ({a_mr[3], a_iod[3], a_asb[3]} !== 4'b1_1_10) $display("FAIL lw_mem_ctl got %b want 1110", {a_mr[3], a_iod[3], a_asb[3]}); else n_pass++;
    n_checks++; if ({a_rw[4], a_rd[4], a_mtr[4]} !== 5'b1_00_01) $display("FAIL lw_wb_ctl got %b want 10001", {a_rw[4], a_rd[4], a_mtr[4]}); else n_pass++;
    run_instr(6'h2b, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    any_rw = 1'b0;
    for (int c = 0; c < 4; c++) any_rw |= a_rw[c];
    n_checks++; if (cyc !== 4) $display("FAIL sw_cycles got %0d want 4", cyc); else n_pass++;
    n_checks++; if ({a_st[3], a_mw[3]} !== 4'b011_1) $display("FAIL sw_mem_write got %b want 0111", {a_st[3], a_mw[3]}); else n_pass++;
    n_checks++; if (any_rw !== 1'b0) $display("FAIL sw_reg_write got %b want 0", any_rw); else n_pass++;
    // Three MEM wait cycles stay one short of the trap.
    run_instr(6'h2b, 6'h00, 1'b0, 20'hFFFC7, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 7) $display("FAIL sw_wait_cycles got %0d want 7", cyc); else n_pass++;
    n_checks++; if (timeout !== 1'b0) $display("FAIL sw_wait_timeout got %b want 0", timeout); else n_pass++;
    n_checks++; if (retired_count !== exp_cnt) $display("FAIL lwsw_count got %0d want %0d", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_bne();
    int cyc;
    run_instr(6'h05, 6'h00, 1'b1, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 3) $display("FAIL bne_taken0_cycles got %0d want 3", cyc); else n_pass++;
    n_checks++; if (a_pcw[2] !== 1'b0) $display("FAIL bne_zero1_pc_write got %b want 0", a_pcw[2]); else n_pass++;
    n_checks++; if (a_cmd[2] !== 3'd1) $display("FAIL bne_command got %0d want 1", a_cmd[2]); else n_pass++;
    run_instr(6'h05, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 3) $display("FAIL bne_taken1_cycles got %0d want 3", cyc); else n_pass++;
    n_checks++; if ({a_pcw[2], a_pcs[2]} !== 3'b1_01) $display("FAIL bne_zero0_pc got %b want 101", {a_pcw[2], a_pcs[2]}); else n_pass++;
    n_checks++; if (retired_count !== exp_cnt) $display("FAIL bne_count got %0d want %0d", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_jal_jr();
    int cyc;
    run_instr(6'h03, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 3) $display("FAIL jal_cycles got %0d want 3", cyc); else n_pass++;
    n_checks++; if ({a_pcw[2], a_pcs[2], a_rw[2], a_rd[2], a_mtr[2]} !== 8'b1_10_1_10_10) $display("FAIL jal_ctl got %b want 11011010", {a_pcw[2], a_pcs[2], a_rw[2], a_rd[2], a_mtr[2]}); else n_pass++;
    run_instr(6'h00, 6'h08, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 3) $display("FAIL jr_cycles got %0d want 3", cyc); else n_pass++;
    n_checks++; if ({a_pcw[2], a_pcs[2], a_rw[2]} !== 4'b1_11_0) $display("FAIL jr_ctl got %b want 1110", {a_pcw[2], a_pcs[2], a_rw[2]}); else n_pass++;
    run_instr(6'h02, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if ({a_pcw[2], a_pcs[2], a_rw[2]} !== 4'b1_10_0) $display("FAIL j_ctl got %b want 1100", {a_pcw[2], a_pcs[2], a_rw[2]}); else n_pass++;
    n_checks++; if (retired_count !== exp_cnt) $display("FAIL jump_count got %0d want %0d", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_alu_ops();
    int cyc;
    run_instr(6'h00, 6'h22, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if ({a_cmd[2], a_asb[2]} !== 5'b001_00) $display("FAIL sub_exec got %b want 00100", {a_cmd[2], a_asb[2]}); else n_pass++;
    run_instr(6'h00, 6'h2a, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (a_cmd[2] !== 3'd2) $display("FAIL slt_command got %0d want 2", a_cmd[2]); else n_pass++;
    run_instr(6'h0e, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if ({a_cmd[2], a_asb[2], a_asa[2]} !== 6'b011_11_1) $display("FAIL xori_exec got %b want 011111", {a_cmd[2], a_asb[2], a_asa[2]}); else n_pass++;
    n_checks++; if ({a_rw[3], a_rd[3], a_mtr[3]} !== 5'b1_00_00) $display("FAIL xori_wb got %b want 10000", {a_rw[3], a_rd[3], a_mtr[3]}); else n_pass++;
    run_instr(6'h08, 6'h00, 1'b0, 20'hFFFFF, cyc);
    exp_cnt++;
    n_checks++; if (cyc !== 4) $display("FAIL addi_cycles got %0d want 4", cyc); else n_pass++;
    n_checks++; if ({a_cmd[2], a_asb[2]} !== 5'b000_10) $display("FAIL addi_exec got %b want 00010", {a_cmd[2], a_asb[2]}); else n_pass++;
    n_checks++; if (retired_count !== exp_cnt) $display("FAIL alu_count got %0d want %0d", retired_count, exp_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_sw();
    opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    #1;
    n_checks++; if ({state, mem_write} !== 4'b011_1) $display("FAIL midsw_pre got %b want 0111", {state, mem_write}); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (state !== 3'd0) $display("FAIL midsw_state got %0d want 0", state); else n_pass++;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL midsw_mem_write got %b want 0", mem_write); else n_pass++;
    n_checks++; if (retired_count !== 4'd0) $display("FAIL midsw_count got %0d want 0", retired_count); else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    n_checks++; if ({state, mem_read} !== 4'b000_1) $display("FAIL midsw_release got %b want 0001", {state, mem_read}); else n_pass++;
    @(posedge clk); #1;
    exp_cnt = 4'd0;
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      run_instr(6'h02, 6'h00, 1'b0, 20'hFFFFF, cyc);
      if (i == 14) begin
        n_checks++; if (retired_count !== 4'd15) $display("FAIL wrap_15 got %0d want 15", retired_count); else n_pass++;
      end
    end
    n_checks++; if (retired_count !== 4'd0) $display("FAIL wrap_0 got %0d want 0", retired_count); else n_pass++;
  endtask

  task automatic test_illegal();
    int cyc;
    logic any_strobe;
    do_reset();
    run_instr(6'h3f, 6'h00, 1'b0, 20'hFFFFF, cyc);
    n_checks++; if (cyc !== 3) $display("FAIL ill_cycles got %0d want 3", cyc); else n_pass++;
    n_checks++; if ({a_st[1], a_st[2]} !== 6'b001_101) $display("FAIL ill_states got %b want 001101", {a_st[1], a_st[2]}); else n_pass++;
    n_checks++; if ({illegal, timeout} !== 2'b10) $display("FAIL ill_flags got %b want 10", {illegal, timeout}); else n_pass++;
    any_strobe = 1'b0;
    mem_ready = 1'b1; opcode = 6'h02;
    for (int c = 0; c < 4; c++) begin
      #1;
      any_strobe |= pc_write | ir_write | reg_write | mem_write | mem_read | retire;
      @(posedge clk); #1;
    end
    n_checks++; if (any_strobe !== 1'b0) $display("FAIL ill_strobes got %b want 0", any_strobe); else n_pass++;
    n_checks++; if ({state, retired_count} !== 7'b101_0000) $display("FAIL ill_hold got %b want 1010000", {state, retired_count}); else n_pass++;
    do_reset();
    n_checks++; if ({state, illegal} !== 4'b000_0) $display("FAIL ill_clear got %b want 0000", {state, illegal}); else n_pass++;
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if ({state, timeout} !== 4'b000_0) $display("FAIL to_early got %b want 0000", {state, timeout}); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (state !== 3'd5) $display("FAIL to_state got %0d want 5", state); else n_pass++;
    n_checks++; if ({timeout, illegal, mem_read} !== 3'b100) $display("FAIL to_flags got %b want 100", {timeout, illegal, mem_read}); else n_pass++;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({state, ir_write} !== 4'b101_0) $display("FAIL to_hold got %b want 1010", {state, ir_write}); else n_pass++;
  endtask

  initial begin
    exp_cnt = 4'd0;
    test_reset();
    test_mem_wait_add();
    test_lw_sw();
    test_bne();
    test_jal_jr();
    test_alu_ops();
    test_reset_mid_sw();
    test_wrap();
    test_illegal();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit reached without finishing");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the MIPS-subset datapath (LW, SW, J, JR, JAL, BNE, XORI, ADDI, ADD, SUB, SLT). It replaces single-cycle opcode decode with a state machine that sequences fetch, decode, execute, memory and writeback over a shared memory port. The block waits on a memory-ready handshake, traps illegal instructions and memory timeouts, and counts retired instructions. It sits between the instruction register/ALU flags and the datapath mux and write-enable controls.

## Interface
Parameters:
- CMD_WIDTH, 3: ALU command width (≥2); codes ADD=0, SUB=1, SLT=2, XOR=3, zero-extended.
- WAIT_LIMIT, 16: maximum consecutive mem_ready-low cycles in one memory state; 0 disables the timeout.
- COUNT_WIDTH, 32: retired-instruction counter width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- opcode  in  6  instruction[31:26] from the IR.
- funct  in  6  instruction[5:0] from the IR.
- mem_ready  in  1  memory accepted the write or returned read data this cycle.
- zero  in  1  ALU zero flag.
- ir_write, pc_write  out  1 each  IR load and PC load strobes.
- pc_source  out  2  PC mux select: 0 = ALU (PC+4), 1 = branch target, 2 = jump target, 3 = register rs.
- mem_read, mem_write  out  1 each  memory strobes.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination select: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write-data select: 0 = ALU, 1 = memory, 2 = PC+4.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = constant 4, 2 = sign-extended imm, 3 = zero-extended imm.
- command  out  CMD_WIDTH  ALU command.
- state  out  3  current state, for debug.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal, timeout  out  1 each  sticky trap flags.
- retired_count  out  COUNT_WIDTH  count of retired instructions; wraps to 0.

## Operation
States are encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Any unlisted output is 0.

- **FETCH**
  - Asserts mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, command=ADD.
  - ir_write, pc_write (pc_source=0) are Mealy outputs, asserted only in the cycle mem_ready=1; that cycle moves to DECODE.
- **DECODE**
  - Latches opcode and funct into internal registers. EXEC, MEM and WB use only the latched copies.
  - Legal instructions are opcode 0x00 with funct 0x20 (ADD), 0x22 (SUB), 0x2a (SLT) or 0x08 (JR), and opcodes 0x23, 0x2b, 0x02, 0x03, 0x05, 0x0e, 0x08.
  - A legal instruction moves to EXEC. Anything else sets illegal and moves to HALT.
- **EXEC**
  - ADD/SUB/SLT: alu_src_a=1, alu_src_b=0, command per funct; next state WB.
  - ADDI, LW, SW: alu_src_a=1, alu_src_b=2, command=ADD. ADDI goes to WB; LW and SW go to MEM.
  - XORI: alu_src_a=1, alu_src_b=3, command=XOR; next state WB.
  - BNE: alu_src_a=1, alu_src_b=0, command=SUB, pc_source=1, pc_write=~zero; retire; next state FETCH.
  - J: pc_write=1, pc_source=2; retire; next state FETCH.
  - JR: pc_write=1, pc_source=3; retire; next state FETCH.
  - JAL: pc_write=1, pc_source=2, reg_write=1, reg_dst=2, mem_to_reg=2, all in the same cycle; retire; next state FETCH.
- **MEM**
  - i_or_d=1, alu_src_a=1, alu_src_b=2, command=ADD, held for the whole state.
  - LW: mem_read=1; on mem_ready, move to WB.
  - SW: mem_write=1; on mem_ready, retire and move to FETCH.
- **WB**
  - reg_write=1.
  - R-type: reg_dst=1, mem_to_reg=0. ADDI/XORI: reg_dst=0, mem_to_reg=0. LW: reg_dst=0, mem_to_reg=1.
  - Retire; next state FETCH.
- **HALT**
  - All strobes 0. The block stays in HALT until reset.
- **Timeout**
  - wait_cnt, width $clog2(WAIT_LIMIT+1), increments each FETCH/MEM cycle with mem_ready=0 and clears on mem_ready=1 or on a state change.
  - If WAIT_LIMIT>0 and a FETCH/MEM cycle with mem_ready=0 finds wait_cnt==WAIT_LIMIT-1, timeout sets and the next state is HALT.
- **Retire**
  - retire=1 in the retiring cycle; retired_count increments on that edge, modulo 2^COUNT_WIDTH.

## Timing
- Reset (reset_n low, asynchronous):
  - state=FETCH, wait_cnt=0, retired_count=0, illegal=0, timeout=0, latched opcode/funct=0.
  - While reset_n is low, pc_write, ir_write, reg_write, mem_write and retire are forced to 0.
  - Reset asserted mid-instruction aborts it; no further strobes are issued.
- Cycle counts with mem_ready=1 every cycle: J/JR/JAL/BNE 3, R-type/ADDI/XORI/SW 4, LW 5. Each memory wait cycle adds 1.
- mem_ready is sampled only in FETCH and MEM and ignored elsewhere.
- zero is sampled combinationally in BNE EXEC only.
- Outputs are combinational from state, latched instruction, mem_ready and zero. No output registers.

## Test plan
- **Reset state:** reset_n=0 mid-MEM of an SW → state=0, mem_write=0 immediately; after release, FETCH with mem_read=1, retired_count=0.
- **Memory waits:** ADD with mem_ready low for 2 FETCH cycles → 6 cycles total; reg_write=1, reg_dst=1 in WB; retired_count=1.
- **LW and SW:** LW (0x23) with mem_ready=1 → states 0,1,2,3,4; mem_to_reg=1 in WB. SW (0x2b) → mem_write in state 3; no reg_write anywhere.
- **BNE:** zero=1 → pc_write=0 in EXEC. zero=0 → pc_write=1, pc_source=1. Both retire after 3 cycles.
- **JAL and JR:** JAL → one EXEC cycle with pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. JR (funct 0x08) → pc_source=3.
- **Traps:**
  - Opcode 0x3f → illegal=1 and HALT after DECODE; no strobes until reset.
  - WAIT_LIMIT=4 with mem_ready stuck low in FETCH → timeout=1 and state=5 after the 4th wait cycle.
  - COUNT_WIDTH=4: 16 retires → retired_count wraps to 0.
